// File: rtl/ex_mem_pkg.sv
// Shared definitions for the execute/memory pipeline boundary.
// Holds bus widths, stall vector bit positions, NOP encodings and the
// per-edge action decode used by ex_mem.
package ex_mem_pkg;

  localparam int REG_BUS        = 32;
  localparam int REG_ADDR_BUS   = 5;
  localparam int ALU_OP_BUS     = 8;
  localparam int DOUBLE_REG_BUS = 64;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;
  localparam logic [ALU_OP_BUS-1:0]   EXE_NOP_OP   = '0;

  // What the boundary register does on a given clock edge.
  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_PASS   = 2'd3
  } stage_action_e;

  // Flush beats everything; a stalled execute with a running memory stage
  // injects a bubble; both stalled freezes; an unstalled execute passes
  // (including the never-seen ex-running/mem-stalled combination).
  function automatic stage_action_e decode_action(input logic flush,
                                                  input logic ex_stall,
                                                  input logic mem_stall);
    stage_action_e act;
    if (flush)
      act = ACT_FLUSH;
    else if (ex_stall && !mem_stall)
      act = ACT_BUBBLE;
    else if (ex_stall && mem_stall)
      act = ACT_HOLD;
    else
      act = ACT_PASS;
    return act;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// ex_mem: pipeline register between execute and memory-access stages.
// Implements the stall/flush protocol for this boundary and, when the
// EX_MEM_HILO_EN macro is defined, carries HI/LO results plus the
// two-cycle multiply-accumulate state fed back to execute.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5:0]                  stall,
  input  logic                        flush,
  input  logic [REG_ADDR_BUS-1:0]     ex_wd,
  input  logic                        ex_wreg,
  input  logic [REG_BUS-1:0]          ex_wdata,
  input  logic [ALU_OP_BUS-1:0]       ex_aluop,
  input  logic [REG_BUS-1:0]          ex_mem_addr,
  input  logic [REG_BUS-1:0]          ex_reg2,
`ifdef EX_MEM_HILO_EN
  input  logic                        ex_whilo,
  input  logic [REG_BUS-1:0]          ex_hi,
  input  logic [REG_BUS-1:0]          ex_lo,
  input  logic [DOUBLE_REG_BUS-1:0]   hilo_i,
  input  logic [1:0]                  cnt_i,
  output logic                        mem_whilo,
  output logic [REG_BUS-1:0]          mem_hi,
  output logic [REG_BUS-1:0]          mem_lo,
  output logic [DOUBLE_REG_BUS-1:0]   hilo_o,
  output logic [1:0]                  cnt_o,
`endif
  output logic [REG_ADDR_BUS-1:0]     mem_wd,
  output logic                        mem_wreg,
  output logic [REG_BUS-1:0]          mem_wdata,
  output logic [ALU_OP_BUS-1:0]       mem_aluop,
  output logic [REG_BUS-1:0]          mem_mem_addr,
  output logic [REG_BUS-1:0]          mem_reg2,
  output logic                        mem_valid
);

  stage_action_e action;

  // Only the execute and memory stall bits matter at this boundary.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  // Decode this edge's action from flush and the two relevant stall bits.
  always_comb begin
    action = decode_action(flush, stall[STALL_EX], stall[STALL_MEM]);
  end

  // GPR / memory-access fields and the valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd       <= NOP_REG_ADDR;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_aluop    <= EXE_NOP_OP;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      mem_valid    <= 1'b0;
    end else begin
      case (action)
        ACT_PASS: begin
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg;
          mem_wdata    <= ex_wdata;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
          mem_valid    <= 1'b1;
        end
        ACT_HOLD: begin
        end
        default: begin
          mem_wd       <= NOP_REG_ADDR;
          mem_wreg     <= 1'b0;
          mem_wdata    <= '0;
          mem_aluop    <= EXE_NOP_OP;
          mem_mem_addr <= '0;
          mem_reg2     <= '0;
          mem_valid    <= 1'b0;
        end
      endcase
    end
  end

`ifdef EX_MEM_HILO_EN
  // HI/LO result fields follow the same pass/hold/bubble rules as GPR fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
    end else begin
      case (action)
        ACT_PASS: begin
          mem_whilo <= ex_whilo;
          mem_hi    <= ex_hi;
          mem_lo    <= ex_lo;
        end
        ACT_HOLD: begin
        end
        default: begin
          mem_whilo <= 1'b0;
          mem_hi    <= '0;
          mem_lo    <= '0;
        end
      endcase
    end
  end

  // Accumulator state is only kept while execute is stalled alone; any
  // pass-through or flush discards it so a new op starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_o <= '0;
      cnt_o  <= 2'b00;
    end else begin
      case (action)
        ACT_BUBBLE: begin
          hilo_o <= hilo_i;
          cnt_o  <= cnt_i;
        end
        ACT_HOLD: begin
        end
        default: begin
          hilo_o <= '0;
          cnt_o  <= 2'b00;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: self-checking bench for ex_mem. A rule-level model predicts the
// outputs each cycle; directed literal checks pin the model. HI/LO checks
// are compiled in only when EX_MEM_HILO_EN is defined.
module tb_ex_mem;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic        mem_valid;
`ifdef EX_MEM_HILO_EN
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`endif

  int total;
  int bad;

  ex_mem dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
`ifdef EX_MEM_HILO_EN
    .ex_whilo     (ex_whilo),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .hilo_i       (hilo_i),
    .cnt_i        (cnt_i),
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .hilo_o       (hilo_o),
    .cnt_o        (cnt_o),
`endif
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .mem_valid    (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected register contents.
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic [7:0]  m_aluop;
  logic [31:0] m_addr;
  logic [31:0] m_reg2;
  logic        m_valid;
  logic        m_whilo;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_hilo;
  logic [1:0]  m_cnt;

  task automatic modelClear();
    m_wd = 0; m_wreg = 0; m_wdata = 0; m_aluop = 0; m_addr = 0; m_reg2 = 0;
    m_valid = 0; m_whilo = 0; m_hi = 0; m_lo = 0;
  endtask

  // Rule-level model: decide from flush/stall which of the four outcomes
  // the boundary takes, then apply it to the expected contents.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelClear();
      m_hilo = 0;
      m_cnt  = 0;
    end else if (flush) begin
      modelClear();
      m_hilo = 0;
      m_cnt  = 0;
    end else if (stall[3] && stall[4]) begin
      // frozen: nothing changes
    end else if (stall[3]) begin
      modelClear();
`ifdef EX_MEM_HILO_EN
      m_hilo = hilo_i;
      m_cnt  = cnt_i;
`endif
    end else begin
      m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata; m_aluop = ex_aluop;
      m_addr = ex_mem_addr; m_reg2 = ex_reg2; m_valid = 1;
`ifdef EX_MEM_HILO_EN
      m_whilo = ex_whilo; m_hi = ex_hi; m_lo = ex_lo;
`endif
      m_hilo = 0;
      m_cnt  = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("mem_wd",       64'(mem_wd),       64'(m_wd));
      checkOutput("mem_wreg",     64'(mem_wreg),     64'(m_wreg));
      checkOutput("mem_wdata",    64'(mem_wdata),    64'(m_wdata));
      checkOutput("mem_aluop",    64'(mem_aluop),    64'(m_aluop));
      checkOutput("mem_mem_addr", 64'(mem_mem_addr), 64'(m_addr));
      checkOutput("mem_reg2",     64'(mem_reg2),     64'(m_reg2));
      checkOutput("mem_valid",    64'(mem_valid),    64'(m_valid));
`ifdef EX_MEM_HILO_EN
      checkOutput("mem_whilo",    64'(mem_whilo),    64'(m_whilo));
      checkOutput("mem_hi",       64'(mem_hi),       64'(m_hi));
      checkOutput("mem_lo",       64'(mem_lo),       64'(m_lo));
      checkOutput("hilo_o",       hilo_o,            m_hilo);
      checkOutput("cnt_o",        64'(cnt_o),        64'(m_cnt));
`endif
    end
  end

  // Drive one vector, let one rising edge consume it, return 2 units later.
  task automatic applyStimulus(input logic [5:0] s, input logic f,
                               input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdata, input logic [7:0] op,
                               input logic [31:0] addr, input logic [31:0] r2,
                               input logic whilo, input logic [31:0] hi,
                               input logic [31:0] lo, input logic [63:0] hl,
                               input logic [1:0] cn);
    stall = s; flush = f; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = r2;
`ifdef EX_MEM_HILO_EN
    ex_whilo = whilo; ex_hi = hi; ex_lo = lo; hilo_i = hl; cnt_i = cn;
`else
    if (whilo || (hi != 0) || (lo != 0) || (hl != 0) || (cn != 0)) begin end
`endif
    @(posedge clk);
    #2;
  endtask

  logic [31:0] held_wdata;
  logic [4:0]  held_wd;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(6'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(6'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Plain pass-through.
    applyStimulus(6'b000000, 0, 5'd3, 1, 32'h1234_5678, 8'h21, 32'h100, 32'hAA, 0, 0, 0, 0, 0);
    checkOutput("pass_wdata", 64'(mem_wdata), 64'h1234_5678);
    checkOutput("pass_wd",    64'(mem_wd),    64'd3);
    checkOutput("pass_valid", 64'(mem_valid), 64'd1);

    // Asynchronous reset mid-cycle clears outputs before any edge.
    rst = 1'b1;
    #1;
    checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_wd",    64'(mem_wd),    64'd0);
    checkOutput("rst_valid", 64'(mem_valid), 64'd0);
    #1;
    rst = 1'b0;

    // Another pass, then stall execute only: bubble plus accumulator capture.
    applyStimulus(6'b000000, 0, 5'd7, 1, 32'hDEAD_BEEF, 8'h23, 32'h200, 32'h55, 0, 0, 0, 0, 0);
    applyStimulus(6'b001111, 0, 5'd9, 1, 32'h0BAD_F00D, 8'h24, 32'h300, 32'h66, 1, 7, 8, 64'hA, 2'd1);
    checkOutput("bub_wreg",  64'(mem_wreg),  64'd0);
    checkOutput("bub_valid", 64'(mem_valid), 64'd0);
`ifdef EX_MEM_HILO_EN
    checkOutput("bub_hilo",  hilo_o,         64'hA);
    checkOutput("bub_cnt",   64'(cnt_o),     64'd1);
    checkOutput("bub_whilo", 64'(mem_whilo), 64'd0);
`endif

    // Release: accumulation result passes, counter returns to zero.
    applyStimulus(6'b000000, 0, 5'd0, 0, 32'h0, 8'h18, 32'h0, 32'h0, 1, 32'h1, 32'h2, 0, 0);
`ifdef EX_MEM_HILO_EN
    checkOutput("acc_hi",    64'(mem_hi),    64'd1);
    checkOutput("acc_lo",    64'(mem_lo),    64'd2);
    checkOutput("acc_whilo", 64'(mem_whilo), 64'd1);
    checkOutput("acc_cnt",   64'(cnt_o),     64'd0);
`endif
    checkOutput("acc_valid", 64'(mem_valid), 64'd1);

    // Valid load, then hold for three cycles with both stages stalled.
    applyStimulus(6'b000000, 0, 5'd12, 1, 32'hCAFE_0001, 8'h25, 32'h400, 32'h77, 0, 0, 0, 0, 0);
    held_wdata = 32'hCAFE_0001;
    held_wd    = 5'd12;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b011111, 0, 5'd1, 0, 32'h1111_1111, 8'h0, 32'h1, 32'h1, 1, 5, 5, 64'h5, 2'd1);
      checkOutput("hold_wdata", 64'(mem_wdata), 64'(held_wdata));
      checkOutput("hold_wd",    64'(mem_wd),    64'(held_wd));
      checkOutput("hold_valid", 64'(mem_valid), 64'd1);
    end

    // Start an accumulation, then flush together with the stall.
    applyStimulus(6'b001111, 0, 5'd4, 1, 32'h4, 8'h4, 32'h4, 32'h4, 0, 0, 0, 64'h1234, 2'd1);
    applyStimulus(6'b001111, 1, 5'd4, 1, 32'h4, 8'h4, 32'h4, 32'h4, 1, 3, 3, 64'h99, 2'd1);
    checkOutput("flush_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("flush_valid", 64'(mem_valid), 64'd0);
`ifdef EX_MEM_HILO_EN
    checkOutput("flush_hilo",  hilo_o,         64'd0);
    checkOutput("flush_cnt",   64'(cnt_o),     64'd0);
`endif

    // Unexpected ex-running/mem-stalled combination behaves as a pass.
    applyStimulus(6'b010000, 0, 5'd31, 1, 32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    checkOutput("odd_wd",    64'(mem_wd),    64'd31);
    checkOutput("odd_valid", 64'(mem_valid), 64'd1);

    // A short mixed run for the per-cycle model comparison.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(6'(i % 3 == 0 ? 6'b001111 : (i % 3 == 1 ? 6'b011111 : 6'b000000)),
                    (i == 7), 5'(i), 1'(i), $urandom, 8'(i), $urandom, $urandom,
                    1'(i), $urandom, $urandom, {$urandom, $urandom}, 2'(i));
    end

    applyStimulus(6'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS32 core. It captures the execute-stage result (write-back target, data, HI/LO update and load/store operands) on each rising clock edge and presents it to the memory stage one cycle later. It also implements the core's stall and flush protocol for this boundary. It holds the two-cycle accumulator state (`hilo_o`, `cnt_o`) that execute needs for multi-cycle multiply-accumulate ops while it is stalled.

## Interface
Parameters: none; all widths come from the shared defines (`RegBus`=32, `RegAddrBus`=5, `AluOpBus`=8, `DoubleRegBus`=64).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high (`RstEnable`=1'b1); one clock domain.
- `stall`  in  6  per-stage stall vector from ctrl; bit 3 = execute, bit 4 = memory.
- `flush`  in  1  exception flush; kills the in-flight instruction.
- `ex_wd`  in  `RegAddrBus`  destination register.
- `ex_wreg`  in  1  GPR write enable.
- `ex_wdata`  in  `RegBus`  result data.
- `ex_aluop`  in  `AluOpBus`  op code, for memory-stage load/store decode.
- `ex_mem_addr`  in  `RegBus`  effective address.
- `ex_reg2`  in  `RegBus`  store data.
- `ex_whilo`, `ex_hi`, `ex_lo`  in  1/`RegBus`/`RegBus`  HI/LO write enable and values (`EX_MEM_HILO_EN` only).
- `hilo_i`  in  `DoubleRegBus`  partial accumulator from execute (`EX_MEM_HILO_EN` only).
- `cnt_i`  in  2  accumulator cycle count from execute (`EX_MEM_HILO_EN` only).
- `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_aluop`, `mem_mem_addr`, `mem_reg2`  out  registered copies of the `ex_*` fields above.
- `mem_whilo`, `mem_hi`, `mem_lo`  out  registered HI/LO fields (`EX_MEM_HILO_EN` only).
- `mem_valid`  out  1  high when the memory stage holds a real instruction, low for a bubble.
- `hilo_o`  out  `DoubleRegBus`  accumulator fed back to execute (`EX_MEM_HILO_EN` only).
- `cnt_o`  out  2  cycle count fed back to execute (`EX_MEM_HILO_EN` only).

## Operation
- Reset: every output is 0, asynchronously. This covers `mem_wd`=`NOPRegAddr`, `mem_aluop`=`EXE_NOP_OP` and `mem_valid`=0.
- Each edge applies the first matching rule:
  1. `flush`=1: load a bubble. All `mem_*` fields are 0, `mem_valid`=0, `hilo_o`=0, `cnt_o`=0.
  2. `stall[3]`=1, `stall[4]`=0: execute is stalled and memory proceeds. Load a bubble into `mem_*` (`mem_valid`=0). Capture `hilo_o`←`hilo_i` and `cnt_o`←`cnt_i`.
  3. `stall[3]`=1, `stall[4]`=1: hold every register, including `hilo_o` and `cnt_o`.
  4. `stall[3]`=0: pass through. `mem_*`←`ex_*` and `mem_valid`←1. Clear `hilo_o` and `cnt_o` to 0.
- The combination `stall[3]`=0, `stall[4]`=1 never occurs because ctrl stalls contiguously. It is treated as rule 4.
- A bubble never writes: `mem_wreg`=0 and `mem_whilo`=0.
- No arithmetic is done in this block; all widths pass through unchanged.

## Timing
- Latency: exactly 1 cycle from `ex_*` to `mem_*`. No combinational path from input to output.
- Accumulator handshake:
  - On cycle N, execute asserts `stall[3]` and presents `hilo_i`/`cnt_i`=1.
  - On cycle N+1, `hilo_o`/`cnt_o`=1 are visible to execute.
  - Execute releases the stall. On the following edge the result passes and `cnt_o` returns to 0.
- Simultaneous `flush` and stall: flush wins. This includes discarding a half-finished accumulation.
- Reset mid-accumulation: `cnt_o`=0 immediately. Execute must restart the op.

## Configuration
- `EX_MEM_HILO_EN` defined: the HI/LO ports, `mem_whilo`/`mem_hi`/`mem_lo`, `hilo_o` and `cnt_o` are present and behave as above.
- `EX_MEM_HILO_EN` undefined: those ports and registers are compiled out. Only GPR, memory-access and valid fields are registered. Stall and flush rules are otherwise identical.

## Structure
- The stall bit indices (`STALL_EX`=3, `STALL_MEM`=4), the bus widths and `NOPRegAddr`/`EXE_NOP_OP` live in the shared defines.
- The block is a single module with no sub-module. An optional generic `pipe_reg` sub-module is not used, because the hold/bubble priority is specific to this stage.

## Test plan
- Assert `rst` asynchronously mid-cycle → all outputs are 0 before the next edge, and `mem_valid`=0.
- Set `ex_wd`=5'd3, `ex_wreg`=1, `ex_wdata`=32'h1234_5678, stall=0 → next edge: `mem_wdata`=32'h1234_5678, `mem_wd`=3, `mem_valid`=1.
- stall=6'b001111, `hilo_i`=64'hA, `cnt_i`=1 → `mem_wreg`=0, `mem_valid`=0, `hilo_o`=64'hA, `cnt_o`=1.
- stall=6'b011111 for 3 cycles after a valid load → all outputs are constant across the three cycles.
- Set `flush`=1 together with stall=6'b001111 → `mem_*`=0, `hilo_o`=0, `cnt_o`=0.
- Release the stall after accumulation, with `ex_whilo`=1, `ex_hi`=32'h1, `ex_lo`=32'h2 → `mem_hi`=1, `mem_lo`=2, `mem_whilo`=1, `cnt_o`=0.
